// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write side, read side, status flags and error clear.
// master drives requests and data; slave is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_param_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, af_q, ae_q;
    logic              ovf_q, udf_q;
    logic              wr_acc, rd_acc;

    // Acceptance depends only on registered flags, so no request-to-flag combinational path exists.
    always_comb begin
        wr_acc  = bus.wr_en && !full_q;
        rd_acc  = bus.rd_en && !empty_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= AF_C);
            ae_q    <= (count_d <= AE_C);
            // A new error event outranks a simultaneous clear.
            ovf_q   <= (ovf_q && !bus.clr_err) || (bus.wr_en && full_q);
            udf_q   <= (udf_q && !bus.clr_err) || (bus.rd_en && empty_q);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.rd_data  = empty_q ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
        assign bus.rd_valid = !empty_q;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one standard-read and one FWFT instance
// sharing clock and reset.
module tb_sync_fifo_param;
    logic clk;
    logic rst;
    int unsigned n_cmp;
    int unsigned n_err;

    sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3)) ifa ();
    sync_fifo_param_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

    sync_fifo_param #(
        .DATA_W(16), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );

    sync_fifo_param #(
        .DATA_W(16), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.clr_err = 1'b0; ifa.wr_data = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        idle_a();
        ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.clr_err = 1'b0; ifb.wr_data = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(ifa.count), 0);
        chk("rst_empty", 32'(ifa.empty), 1);
        chk("rst_full", 32'(ifa.full), 0);
        chk("rst_ae", 32'(ifa.almost_empty), 1);
        chk("rst_af", 32'(ifa.almost_full), 0);
        chk("rst_rdata", 32'(ifa.rd_data), 0);
        chk("rst_rvalid", 32'(ifa.rd_valid), 0);
        chk("rst_ovf", 32'(ifa.overflow), 0);
        chk("rst_udf", 32'(ifa.underflow), 0);

        // 1: fill 1..8, then overflow
        for (int unsigned i = 1; i <= 8; i++) begin
            ifa.wr_en = 1'b1;
            ifa.wr_data = 16'(i);
            step();
            chk("fill_count", 32'(ifa.count), i);
            chk("fill_ae", 32'(ifa.almost_empty), (i <= 2) ? 1 : 0);
            chk("fill_af", 32'(ifa.almost_full), (i >= 6) ? 1 : 0);
            chk("fill_full", 32'(ifa.full), (i == 8) ? 1 : 0);
        end
        ifa.wr_data = 16'h0009;
        step();
        chk("ovf_count", 32'(ifa.count), 8);
        chk("ovf_flag", 32'(ifa.overflow), 1);
        idle_a();

        // 2: drain 1..8, then underflow
        for (int unsigned i = 1; i <= 8; i++) begin
            ifa.rd_en = 1'b1;
            step();
            chk("drain_data", 32'(ifa.rd_data), i);
            chk("drain_valid", 32'(ifa.rd_valid), 1);
            chk("drain_count", 32'(ifa.count), 8 - i);
            chk("drain_empty", 32'(ifa.empty), (i == 8) ? 1 : 0);
        end
        step();
        chk("udf_flag", 32'(ifa.underflow), 1);
        chk("udf_valid", 32'(ifa.rd_valid), 0);
        chk("udf_hold", 32'(ifa.rd_data), 8);
        idle_a();
        ifa.clr_err = 1'b1;
        step();
        chk("clr_ovf", 32'(ifa.overflow), 0);
        chk("clr_udf", 32'(ifa.underflow), 0);
        idle_a();

        // 3: preload 4, then 20 cycles of simultaneous read/write across pointer wrap
        for (int unsigned i = 0; i < 4; i++) begin
            ifa.wr_en = 1'b1;
            ifa.wr_data = 16'(32'h100 + i);
            step();
        end
        chk("pre_count", 32'(ifa.count), 4);
        for (int unsigned j = 0; j < 20; j++) begin
            ifa.wr_en = 1'b1;
            ifa.rd_en = 1'b1;
            ifa.wr_data = 16'(32'h104 + j);
            step();
            chk("rw_data", 32'(ifa.rd_data), 32'h100 + j);
            chk("rw_valid", 32'(ifa.rd_valid), 1);
            chk("rw_count", 32'(ifa.count), 4);
        end
        ifa.wr_en = 1'b0;
        for (int unsigned j = 0; j < 4; j++) begin
            step();
            chk("rw_tail", 32'(ifa.rd_data), 32'h114 + j);
        end
        chk("rw_empty", 32'(ifa.empty), 1);
        idle_a();

        // 4: full with simultaneous read and write -> read wins, 0xDEAD dropped
        for (int unsigned i = 0; i < 8; i++) begin
            ifa.wr_en = 1'b1;
            ifa.wr_data = 16'(32'h200 + i);
            step();
        end
        chk("f4_full", 32'(ifa.full), 1);
        ifa.wr_en = 1'b1;
        ifa.rd_en = 1'b1;
        ifa.wr_data = 16'hDEAD;
        step();
        chk("f4_count", 32'(ifa.count), 7);
        chk("f4_ovf", 32'(ifa.overflow), 1);
        chk("f4_data", 32'(ifa.rd_data), 32'h200);
        idle_a();
        ifa.clr_err = 1'b1;
        step();
        chk("f4_clr", 32'(ifa.overflow), 0);
        idle_a();
        ifa.rd_en = 1'b1;
        for (int unsigned i = 1; i < 8; i++) begin
            step();
            chk("f4_drain", 32'(ifa.rd_data), 32'h200 + i);
        end
        chk("f4_empty", 32'(ifa.empty), 1);
        idle_a();

        // 5: FWFT instance
        chk("fw_rst_empty", 32'(ifb.empty), 1);
        chk("fw_rst_valid", 32'(ifb.rd_valid), 0);
        ifb.wr_en = 1'b1;
        ifb.wr_data = 16'hABCD;
        step();
        ifb.wr_en = 1'b0;
        chk("fw_empty", 32'(ifb.empty), 0);
        chk("fw_valid", 32'(ifb.rd_valid), 1);
        chk("fw_data", 32'(ifb.rd_data), 32'hABCD);
        ifb.rd_en = 1'b1;
        step();
        ifb.rd_en = 1'b0;
        chk("fw_pop_empty", 32'(ifb.empty), 1);
        chk("fw_pop_valid", 32'(ifb.rd_valid), 0);
        ifb.wr_en = 1'b1;
        ifb.wr_data = 16'h1111;
        step();
        ifb.wr_data = 16'h2222;
        step();
        ifb.wr_en = 1'b0;
        chk("fw_head1", 32'(ifb.rd_data), 32'h1111);
        ifb.rd_en = 1'b1;
        step();
        ifb.rd_en = 1'b0;
        chk("fw_head2", 32'(ifb.rd_data), 32'h2222);
        chk("fw_valid2", 32'(ifb.rd_valid), 1);

        // 6: reset mid-operation at count=5 with overflow set
        for (int unsigned i = 0; i < 9; i++) begin
            ifa.wr_en = 1'b1;
            ifa.wr_data = 16'(32'h300 + i);
            step();
        end
        ifa.wr_en = 1'b0;
        ifa.rd_en = 1'b1;
        step();
        step();
        step();
        ifa.rd_en = 1'b0;
        chk("r6_pre_count", 32'(ifa.count), 5);
        chk("r6_pre_ovf", 32'(ifa.overflow), 1);
        rst = 1'b1;
        ifa.wr_en = 1'b1;
        ifa.wr_data = 16'h5555;
        step();
        rst = 1'b0;
        ifa.wr_en = 1'b0;
        chk("r6_count", 32'(ifa.count), 0);
        chk("r6_empty", 32'(ifa.empty), 1);
        chk("r6_ae", 32'(ifa.almost_empty), 1);
        chk("r6_ovf", 32'(ifa.overflow), 0);
        chk("r6_valid", 32'(ifa.rd_valid), 0);
        ifa.wr_en = 1'b1;
        ifa.wr_data = 16'h0777;
        step();
        ifa.wr_en = 1'b0;
        chk("r6_addr0", 32'(dut_a.mem_q[0]), 32'h0777);
        chk("r6_count1", 32'(ifa.count), 1);
        ifa.rd_en = 1'b1;
        step();
        ifa.rd_en = 1'b0;
        chk("r6_read", 32'(ifa.rd_data), 32'h0777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
